// File: rtl/mem_router.sv
// Registered CPU-to-memory address router: decodes a request into one of REGIONS windows,
// inserts per-region wait states and returns latched read data with a one-cycle ready strobe.
// Optional write protection is enabled by defining MEM_ROUTER_WPROT_EN.
module mem_router #(
  parameter int                        ADDR_W      = 20,
  parameter int                        DATA_W      = 8,
  parameter int                        REGIONS     = 3,
  parameter logic [REGIONS*ADDR_W-1:0] REGION_BASE = {20'hFE000, 20'hB8000, 20'h0},
  parameter logic [REGIONS*ADDR_W-1:0] REGION_MASK = {20'hFE000, 20'hFC000, 20'hFC000},
  parameter logic [REGIONS*4-1:0]      REGION_WAIT = {4'd1, 4'd1, 4'd1},
  parameter logic [REGIONS-1:0]        WPROT       = 3'b100
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [ADDR_W-1:0]           cpu_address,
  input  logic                        cpu_req,
  input  logic                        cpu_we,
  input  logic [DATA_W-1:0]           cpu_wdata,
  output logic [DATA_W-1:0]           cpu_rdata,
  output logic                        cpu_ready,
  output logic                        cpu_fault,
  output logic [ADDR_W-1:0]           mem_address,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic [REGIONS-1:0]          mem_sel,
  output logic [REGIONS-1:0]          mem_we,
  input  logic [REGIONS*DATA_W-1:0]   mem_rdata,
  output logic                        dbg_state
);

  localparam int IDX_W = (REGIONS > 1) ? $clog2(REGIONS) : 1;

`ifdef MEM_ROUTER_WPROT_EN
  localparam logic WPROT_ON = 1'b1;
`else
  localparam logic WPROT_ON = 1'b0;
`endif

  localparam logic [REGIONS-1:0] WPROT_MASK = WPROT & {REGIONS{WPROT_ON}};

  // Handshake: cpu_req is only sampled in IDLE; each accepted request yields exactly
  // one cpu_ready pulse (with cpu_fault alongside when the access was refused).
  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t             state;
  logic [IDX_W-1:0]   reg_idx;
  logic               reg_hit;
  logic               reg_we;
  logic               reg_fault;
  logic [3:0]         cnt;

  logic               dec_hit;
  logic [IDX_W-1:0]   dec_idx;
  logic               dec_prot;
  logic [3:0]         dec_wait;
  logic [REGIONS-1:0] dec_onehot;
  logic [DATA_W-1:0]  rdata_sel;

  // Scanning from the top index down lets the lowest matching region win.
  always_comb begin
    dec_hit    = 1'b0;
    dec_idx    = '0;
    dec_prot   = 1'b0;
    dec_wait   = '0;
    dec_onehot = '0;
    for (int r = REGIONS - 1; r >= 0; r--) begin
      if (((cpu_address ^ REGION_BASE[r*ADDR_W +: ADDR_W]) &
           REGION_MASK[r*ADDR_W +: ADDR_W]) == '0) begin
        dec_hit       = 1'b1;
        dec_idx       = IDX_W'(r);
        dec_prot      = WPROT_MASK[r];
        dec_wait      = REGION_WAIT[r*4 +: 4];
        dec_onehot    = '0;
        dec_onehot[r] = 1'b1;
      end
    end
  end

  always_comb begin
    rdata_sel = '1;
    for (int r = 0; r < REGIONS; r++) begin
      if (reg_hit && reg_idx == IDX_W'(r)) rdata_sel = mem_rdata[r*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cpu_rdata   <= '1;
      cpu_ready   <= 1'b0;
      cpu_fault   <= 1'b0;
      mem_sel     <= '0;
      mem_we      <= '0;
      mem_address <= '0;
      mem_wdata   <= '0;
      reg_idx     <= '0;
      reg_hit     <= 1'b0;
      reg_we      <= 1'b0;
      reg_fault   <= 1'b0;
      cnt         <= '0;
    end else begin
      cpu_ready <= 1'b0;
      cpu_fault <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            mem_address <= cpu_address;
            mem_wdata   <= cpu_wdata;
            reg_idx     <= dec_idx;
            reg_hit     <= dec_hit;
            reg_we      <= cpu_we;
            reg_fault   <= !dec_hit || (cpu_we && dec_prot);
            cnt         <= dec_hit ? dec_wait : 4'd0;
            mem_sel     <= dec_onehot;
            mem_we      <= (cpu_we && !dec_prot) ? dec_onehot : '0;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          mem_we <= '0;
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (!reg_we) cpu_rdata <= rdata_sel;
            cpu_ready <= 1'b1;
            cpu_fault <= reg_fault;
            mem_sel   <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dbg_state = (state == ACCESS);

endmodule
